// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS core: sequencer state encoding
// and the jump address that halts the core.
package cpu_pkg;

  typedef enum logic [3:0] {
    HALT   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    EXEC1  = 4'd3,
    EXEC2  = 4'd4
  } state_t;

  localparam logic [31:0] HALT_ADDR = 32'h0000_0000;

  function automatic logic is_halt_target(input logic [31:0] addr);
    return addr == HALT_ADDR;
  endfunction

endpackage

// File: rtl/delay_slot_tracker.sv
// Remembers a taken branch until its delay slot retires, then hands the
// target to the PC and flags a halt when that target is the halt address.
module delay_slot_tracker
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        retire,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        delay_pending,
  output logic [31:0] redirect_target,
  output logic        halt_on_retire
);

  // Only meaningful together with retire: the delay slot of a jump to the halt address.
  assign halt_on_retire = delay_pending && is_halt_target(redirect_target);

  // A branch in a delay slot chains a new pending redirect, unless the core is
  // halting, in which case that branch is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      delay_pending   <= 1'b0;
      redirect_target <= 32'h0;
    end else if (retire) begin
      if (halt_on_retire) begin
        delay_pending <= 1'b0;
      end else if (branch_taken) begin
        delay_pending   <= 1'b1;
        redirect_target <= branch_target;
      end else begin
        delay_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle state sequencer: steps FETCH/DECODE/EXEC1/EXEC2, stalls on the
// Avalon waitrequest, counts retired instructions and halts on a jump to 0.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter state_t RESET_STATE = FETCH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic        mem_access,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [3:0]  state,
  output logic        active,
  output logic        stall,
  output logic        retire,
  output logic        pc_redirect,
  output logic [31:0] redirect_target,
  output logic        delay_pending,
  output logic [31:0] instr_count
);

  state_t state_q;
  state_t state_next;
  logic   halt_on_retire;

  delay_slot_tracker u_delay_slot_tracker (
    .clk             (clk),
    .reset           (reset),
    .retire          (retire),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .delay_pending   (delay_pending),
    .redirect_target (redirect_target),
    .halt_on_retire  (halt_on_retire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      instr_count <= 32'h0;
    end else begin
      state_q <= state_next;
      if (retire) begin
        instr_count <= instr_count + 32'd1;
      end
    end
  end

  // EXEC1 only waits on memory when the control unit is actually accessing it.
  always_comb begin
    state_next = state_q;
    stall      = 1'b0;
    case (state_q)
      HALT:   state_next = HALT;
      FETCH: begin
        if (waitrequest) stall = 1'b1;
        else             state_next = DECODE;
      end
      DECODE: state_next = EXEC1;
      EXEC1: begin
        if (mem_access && waitrequest) stall = 1'b1;
        else                           state_next = EXEC2;
      end
      EXEC2: begin
        if (waitrequest)         stall = 1'b1;
        else if (halt_on_retire) state_next = HALT;
        else                     state_next = FETCH;
      end
      default: state_next = RESET_STATE;
    endcase
  end

  assign retire      = (state_q == EXEC2) && !waitrequest;
  assign pc_redirect = retire && delay_pending;
  assign active      = (state_q != HALT);
  assign state       = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: instruction-level stimulus plans push
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        waitrequest = 1'b0;
  logic        mem_access = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [3:0]  state;
  logic        active;
  logic        stall;
  logic        retire;
  logic        pc_redirect;
  logic [31:0] redirect_target;
  logic        delay_pending;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          chk;
    logic [3:0]  st;
    logic        stl;
    logic        ret;
    logic        pcr;
    logic [31:0] tgt;
    logic        dp;
    logic [31:0] cnt;
    logic        act;
  } exp_t;

  exp_t exp_q[$];

  // Instruction-level reference: the pending delay-slot redirect and retire count.
  logic [31:0] m_count;
  logic        m_dp;
  logic [31:0] m_tgt;
  bit          m_halted;

  cpu_sequencer #(.RESET_STATE(cpu_pkg::FETCH)) dut (
    .clk             (clk),
    .reset           (reset),
    .waitrequest     (waitrequest),
    .mem_access      (mem_access),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .state           (state),
    .active          (active),
    .stall           (stall),
    .retire          (retire),
    .pc_redirect     (pc_redirect),
    .redirect_target (redirect_target),
    .delay_pending   (delay_pending),
    .instr_count     (instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic exp_t mk(input logic [3:0] st, input logic stl, input logic ret, input logic pcr);
    exp_t e;
    e.chk = 1'b1;
    e.st  = st;
    e.stl = stl;
    e.ret = ret;
    e.pcr = pcr;
    e.tgt = m_tgt;
    e.dp  = m_dp;
    e.cnt = m_count;
    e.act = (st != 4'd0);
    return e;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk) begin
        check_output("state",           32'(state),         32'(e.st));
        check_output("active",          32'(active),        32'(e.act));
        check_output("stall",           32'(stall),         32'(e.stl));
        check_output("retire",          32'(retire),        32'(e.ret));
        check_output("pc_redirect",     32'(pc_redirect),   32'(e.pcr));
        check_output("redirect_target", redirect_target,    e.tgt);
        check_output("delay_pending",   32'(delay_pending), 32'(e.dp));
        check_output("instr_count",     instr_count,        e.cnt);
      end
    end
  end

  task automatic drive_cycle(input logic wr, input logic mem, input logic br,
                             input logic [31:0] bt, input logic rst, input exp_t e);
    waitrequest   = wr;
    mem_access    = mem;
    branch_taken  = br;
    branch_target = bt;
    reset         = rst;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_count  = 32'h0;
    m_dp     = 1'b0;
    m_tgt    = 32'h0;
    m_halted = 1'b0;
  endtask

  task automatic do_reset();
    exp_t e;
    e = mk(4'd0, 1'b0, 1'b0, 1'b0);
    e.chk = 1'b0;
    drive_cycle(rb(), rb(), rb(), $urandom, 1'b1, e);
    model_reset();
  endtask

  // One instruction: wf/we/wx wait cycles in FETCH/EXEC1/EXEC2; rst_x resets
  // during the first EXEC2 wait cycle instead of retiring.
  task automatic apply_stimulus(input int wf, input bit mem, input int we, input int wx,
                                input logic br, input logic [31:0] bt, input bit rst_x);
    for (int i = 0; i < wf; i++) drive_cycle(1'b1, rb(), rb(), $urandom, 1'b0, mk(4'd1, 1'b1, 1'b0, 1'b0));
    drive_cycle(1'b0, rb(), rb(), $urandom, 1'b0, mk(4'd1, 1'b0, 1'b0, 1'b0));
    drive_cycle(rb(), rb(), rb(), $urandom, 1'b0, mk(4'd2, 1'b0, 1'b0, 1'b0));
    if (mem) begin
      for (int i = 0; i < we; i++) drive_cycle(1'b1, 1'b1, rb(), $urandom, 1'b0, mk(4'd3, 1'b1, 1'b0, 1'b0));
      drive_cycle(1'b0, 1'b1, rb(), $urandom, 1'b0, mk(4'd3, 1'b0, 1'b0, 1'b0));
    end else begin
      drive_cycle(rb(), 1'b0, rb(), $urandom, 1'b0, mk(4'd3, 1'b0, 1'b0, 1'b0));
    end
    for (int i = 0; i < wx; i++) begin
      if (rst_x) begin
        drive_cycle(1'b1, rb(), rb(), $urandom, 1'b1, mk(4'd4, 1'b1, 1'b0, 1'b0));
        model_reset();
        return;
      end
      drive_cycle(1'b1, rb(), rb(), $urandom, 1'b0, mk(4'd4, 1'b1, 1'b0, 1'b0));
    end
    drive_cycle(1'b0, rb(), br, bt, 1'b0, mk(4'd4, 1'b0, 1'b1, m_dp));
    m_count = m_count + 32'd1;
    if (m_dp && m_tgt == 32'h0) begin
      m_halted = 1'b1;
      m_dp     = 1'b0;
    end else if (br) begin
      m_dp  = 1'b1;
      m_tgt = bt;
    end else begin
      m_dp = 1'b0;
    end
  endtask

  task automatic run_halt(input int n);
    for (int i = 0; i < n; i++) drive_cycle(rb(), rb(), rb(), $urandom, 1'b0, mk(4'd0, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    do_reset();

    for (int i = 0; i < 3; i++) apply_stimulus(0, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0);
    apply_stimulus(3, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0);
    apply_stimulus(0, 1'b1, 2, 0, 1'b0, 32'h0, 1'b0);
    apply_stimulus(0, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0);
    apply_stimulus(0, 1'b0, 0, 0, 1'b1, 32'h0000_1000, 1'b0);
    apply_stimulus(0, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0);
    apply_stimulus(1, 1'b0, 0, 1, 1'b1, 32'h0, 1'b0);
    apply_stimulus(0, 1'b0, 0, 0, 1'b1, 32'h0000_2000, 1'b0);
    run_halt(10);
    do_reset();
    apply_stimulus(0, 1'b0, 0, 0, 1'b1, 32'h0000_3000, 1'b0);
    apply_stimulus(0, 1'b1, 1, 2, 1'b0, 32'h0, 1'b1);
    apply_stimulus(0, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      if (m_halted) begin
        run_halt($urandom_range(1, 5));
        do_reset();
      end else begin
        int wf, we, wx;
        bit mem, br, rst_x;
        logic [31:0] bt;
        wf    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
        mem   = rb();
        we    = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3) : 0;
        wx    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
        br    = ($urandom_range(0, 2) == 0);
        bt    = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        rst_x = (wx > 0) && ($urandom_range(0, 19) == 0);
        apply_stimulus(wf, mem, we, wx, br, bt, rst_x);
      end
    end

    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
